// File: rtl/aes_round_seq.sv
// Round/step sequencer for the byte-serial AES datapath.
// Owns step, round and rcon counters; decodes column enables and mux selects.
module aes_seq_cg (
  input  logic clk,
  input  logic en,
  output logic clk_out
);
  logic en_l;

  always_latch begin
    if (!clk) en_l <= en;
  end

  assign clk_out = clk & en_l;
endmodule

module aes_round_seq #(
  parameter int NUM_COLS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                enc_dec,
  input  logic [1:0]          key_len,
  input  logic                key_changed,
  input  logic                stall,
  output logic [NUM_COLS:0]   clk_en,
  output logic [NUM_COLS:0]   clk_out,
  output logic [NUM_COLS:0]   se,
  output logic                sb_sel,
  output logic                in_round_sel,
  output logic                last_rnd_sel,
  output logic [7:0]          rcon,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                key_ready,
  output logic                done
);
  localparam int STEPS  = 4 * (NUM_COLS + 1);
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    S_IDLE, S_KEYEXP, S_RUN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        round_q, round_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              key_ready_q, key_ready_d;
  logic              enc_q, enc_d;
  logic [3:0]        nr_q, nr_d;

  logic              fwd, first_rnd, last_rnd, wrap, shift, run;
  logic [NUM_COLS:0] ce, se_v;

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] n;
    case (kl)
      2'd1:    n = 4'd12;
      2'd2:    n = 4'd14;
      default: n = 4'd10;
    endcase
    return n;
  endfunction

  // Round constant of the final round, where decryption starts.
  function automatic logic [7:0] rcon_last(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd12:   r = 8'hd8;
      4'd14:   r = 8'h4d;
      default: r = 8'h36;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  assign fwd       = enc_q || (state_q == S_KEYEXP);
  assign first_rnd = fwd ? (round_q == 4'd1) : (round_q == nr_q);
  assign last_rnd  = fwd ? (round_q == nr_q) : (round_q == 4'd1);
  assign wrap      = (step_q == STEP_W'(STEPS - 1));
  assign shift     = (step_q >= STEP_W'(4 * NUM_COLS));
  assign run       = (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    key_ready_d = key_ready_q;
    enc_d       = enc_q;
    nr_d        = nr_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stall) begin
          enc_d  = enc_dec;
          nr_d   = nr_of(key_len);
          step_d = '0;
          if (key_changed) key_ready_d = 1'b0;
          if (!enc_dec && (key_changed || !key_ready_q)) begin
            state_d = S_KEYEXP;
            round_d = 4'd1;
            rcon_d  = 8'h01;
          end else begin
            state_d = S_RUN;
            round_d = enc_dec ? 4'd1 : nr_of(key_len);
            rcon_d  = enc_dec ? 8'h01 : rcon_last(nr_of(key_len));
          end
        end
      end
      S_KEYEXP, S_RUN: begin
        if (!stall) begin
          if (wrap) begin
            step_d = '0;
            if (last_rnd) begin
              if (state_q == S_KEYEXP) begin
                state_d     = S_RUN;
                key_ready_d = 1'b1;
                round_d     = nr_q;
                rcon_d      = rcon_last(nr_q);
              end else begin
                state_d = S_DONE;
              end
            end else begin
              round_d = fwd ? round_q + 4'd1 : round_q - 4'd1;
              rcon_d  = fwd ? xtime(rcon_q) : inv_xtime(rcon_q);
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
        round_d = 4'd1;
        rcon_d  = 8'h01;
        enc_d   = 1'b1;
        nr_d    = 4'd10;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      round_q     <= 4'd1;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b0;
      enc_q       <= 1'b1;
      nr_q        <= 4'd10;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      key_ready_q <= key_ready_d;
      enc_q       <= enc_d;
      nr_q        <= nr_d;
    end
  end

  // Column k drains left-to-right in encrypt, right-to-left in decrypt.
  always_comb begin
    ce   = '0;
    se_v = '0;
    if (run) begin
      ce = '1;
      for (int k = 1; k < NUM_COLS; k++) begin
        if (enc_q && !last_rnd && step_q == STEP_W'(4 * (k + 1) - 1)) begin
          for (int i = 0; i < NUM_COLS; i++) begin
            if (i >= NUM_COLS - k) begin
              ce[i]   = 1'b0;
              se_v[i] = 1'b1;
            end
          end
        end
        if (!enc_q && !first_rnd && step_q == STEP_W'(4 * k - 1)) begin
          for (int i = 0; i < NUM_COLS; i++) begin
            if (i <= NUM_COLS - 1 - k) begin
              ce[i]   = 1'b0;
              se_v[i] = 1'b1;
            end
          end
        end
      end
      if (shift) begin
        ce   = last_rnd ? '0 : '1;
        se_v = '0;
        se_v[NUM_COLS] = !last_rnd;
      end
      if (stall) ce = '0;
    end
  end

  assign clk_en       = ce;
  assign se           = se_v;
  assign sb_sel       = run && shift;
  assign in_round_sel = !first_rnd;
  assign last_rnd_sel = !last_rnd;
  assign rcon         = rcon_q;
  assign round_idx    = round_q;
  assign busy         = (state_q != S_IDLE);
  assign key_ready    = key_ready_q;
  assign done         = (state_q == S_DONE);

  for (genvar g = 0; g <= NUM_COLS; g++) begin : g_cg
    aes_seq_cg u_cg (
      .clk     (clk),
      .en      (clk_en[g]),
      .clk_out (clk_out[g])
    );
  end
endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: latencies, enables, rcon and reset.
// Cycle c after an accepted start is logged; expected values are hand-derived.
module tb_aes_round_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       enc_dec = 1'b1;
  logic [1:0] key_len = 2'd0;
  logic       key_changed = 1'b0;
  logic       stall = 1'b0;
  logic [4:0] clk_en, clk_out, se;
  logic       sb_sel, in_round_sel, last_rnd_sel;
  logic [7:0] rcon;
  logic [3:0] round_idx;
  logic       busy, key_ready, done;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  logic [4:0] ce_l [0:1023];
  logic [4:0] se_l [0:1023];
  logic [7:0] rc_l [0:1023];
  logic [3:0] rd_l [0:1023];
  logic       sb_l [0:1023];
  logic       kr_l [0:1023];
  logic       ir_l [0:1023];
  logic       lr_l [0:1023];
  logic       by_l [0:1023];

  aes_round_seq #(.NUM_COLS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .enc_dec      (enc_dec),
    .key_len      (key_len),
    .key_changed  (key_changed),
    .stall        (stall),
    .clk_en       (clk_en),
    .clk_out      (clk_out),
    .se           (se),
    .sb_sel       (sb_sel),
    .in_round_sel (in_round_sel),
    .last_rnd_sel (last_rnd_sel),
    .rcon         (rcon),
    .round_idx    (round_idx),
    .busy         (busy),
    .key_ready    (key_ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce"}, 32'(clk_en), 0);
    chk({tag, "_se"}, 32'(se), 0);
    chk({tag, "_sb"}, 32'(sb_sel), 0);
    chk({tag, "_rcon"}, 32'(rcon), 'h01);
    chk({tag, "_rnd"}, 32'(round_idx), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_kr"}, 32'(key_ready), 0);
    chk({tag, "_irs"}, 32'(in_round_sel), 0);
    chk({tag, "_lrs"}, 32'(last_rnd_sel), 1);
  endtask

  // Start a block, log each cycle, return cycles from start to done.
  task automatic run_block(input logic enc, input logic [1:0] kl,
                           input logic kc, input int st_at,
                           input int st_len, output int l);
    @(negedge clk);
    enc_dec     = enc;
    key_len     = kl;
    key_changed = kc;
    start       = 1'b1;
    l = 0;
    while (l < 1000) begin
      @(negedge clk);
      l++;
      start = (l == 30);
      stall = (st_at > 0) && (l >= st_at) && (l < st_at + st_len);
      #1;
      ce_l[l] = clk_en;
      se_l[l] = se;
      rc_l[l] = rcon;
      rd_l[l] = round_idx;
      sb_l[l] = sb_sel;
      kr_l[l] = key_ready;
      ir_l[l] = in_round_sel;
      lr_l[l] = last_rnd_sel;
      by_l[l] = busy;
      if (done) break;
    end
    start = 1'b0;
    stall = 1'b0;
    if (!done) chk("timeout", 32'(l), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);

    // Encrypt AES-128
    run_block(1'b1, 2'd0, 1'b0, 0, 0, lat);
    chk("enc_lat", 32'(lat), 201);
    chk("enc_busy", 32'(by_l[1]), 1);
    chk("enc_irs_r1", 32'(ir_l[1]), 0);
    chk("enc_irs_r2", 32'(ir_l[21]), 1);
    chk("enc_ce_r1s7", 32'(ce_l[8]), 32'(5'b10111));
    chk("enc_se_r1s7", 32'(se_l[8]), 32'(5'b01000));
    chk("enc_ce_r1s11", 32'(ce_l[12]), 32'(5'b10011));
    chk("enc_se_r1s11", 32'(se_l[12]), 32'(5'b01100));
    chk("enc_ce_r1s16", 32'(ce_l[17]), 32'(5'b11111));
    chk("enc_se_r1s16", 32'(se_l[17]), 32'(5'b10000));
    chk("enc_sb_r1s16", 32'(sb_l[17]), 1);
    chk("enc_rcon_r2", 32'(rc_l[21]), 'h02);
    chk("enc_rnd_r10", 32'(rd_l[181]), 10);
    chk("enc_rcon_r10", 32'(rc_l[181]), 'h36);
    chk("enc_lrs_r10", 32'(lr_l[181]), 0);
    chk("enc_ce_r10s7", 32'(ce_l[188]), 32'(5'b11111));
    chk("enc_se_r10s7", 32'(se_l[188]), 0);
    chk("enc_ce_r10s16", 32'(ce_l[197]), 0);
    chk("enc_se_r10s16", 32'(se_l[197]), 0);

    // Decrypt with new key: KEYEXP then RUN
    run_block(1'b0, 2'd0, 1'b1, 0, 0, lat);
    chk("dec_kx_lat", 32'(lat), 401);
    chk("dec_kx_ce", 32'(ce_l[100]), 0);
    chk("dec_kx_se", 32'(se_l[100]), 0);
    chk("dec_kx_kr", 32'(kr_l[100]), 0);
    chk("dec_kr", 32'(kr_l[201]), 1);
    chk("dec_rnd0", 32'(rd_l[201]), 10);
    chk("dec_rcon0", 32'(rc_l[201]), 'h36);
    chk("dec_irs_r10", 32'(ir_l[201]), 0);
    chk("dec_ce_r10s3", 32'(ce_l[204]), 32'(5'b11111));
    chk("dec_se_r10s3", 32'(se_l[204]), 0);
    chk("dec_rcon_r9", 32'(rc_l[221]), 'h1b);
    chk("dec_ce_r9s3", 32'(ce_l[224]), 32'(5'b11000));
    chk("dec_se_r9s3", 32'(se_l[224]), 32'(5'b00111));
    chk("dec_ce_r9s7", 32'(ce_l[228]), 32'(5'b11100));
    chk("dec_lrs_r1", 32'(lr_l[381]), 0);
    chk("dec_ce_r1s16", 32'(ce_l[397]), 0);
    chk("dec_se_r1s16", 32'(se_l[397]), 0);

    // Back-to-back decrypt, same key
    run_block(1'b0, 2'd0, 1'b0, 0, 0, lat);
    chk("dec2_lat", 32'(lat), 201);
    chk("dec2_kr", 32'(kr_l[1]), 1);
    chk("dec2_rcon0", 32'(rc_l[1]), 'h36);
    chk("dec2_kr_end", 32'(key_ready), 1);

    // AES-256 and key_len=3
    run_block(1'b1, 2'd2, 1'b0, 0, 0, lat);
    chk("k256_lat", 32'(lat), 281);
    chk("k256_rnd14", 32'(rd_l[261]), 14);
    chk("k256_rcon14", 32'(rc_l[261]), 'h4d);
    run_block(1'b1, 2'd3, 1'b0, 0, 0, lat);
    chk("k3_lat", 32'(lat), 201);

    // Stall 5 cycles at round 3 step 10
    run_block(1'b1, 2'd0, 1'b0, 51, 5, lat);
    chk("stall_lat", 32'(lat), 206);
    chk("stall_ce", 32'(ce_l[53]), 0);
    chk("stall_rcon", 32'(rc_l[53]), 'h04);
    chk("stall_rnd", 32'(rd_l[55]), 3);
    chk("stall_ce_after", 32'(ce_l[56]), 32'(5'b11111));
    chk("stall_ce_r3s11", 32'(ce_l[57]), 32'(5'b10011));

    // Reset in round 5
    @(negedge clk);
    enc_dec = 1'b1;
    key_len = 2'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (84) @(negedge clk);
    chk("mid_rnd5", 32'(round_idx), 5);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    run_block(1'b1, 2'd0, 1'b0, 0, 0, lat);
    chk("post_rst_lat", 32'(lat), 201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
